// File: rtl/exe_stage_ctrl.sv
// EXE stage valid/ready control with an optional multi-cycle divide stall.
// Optional feature macro: EXE_DIV_STALL_EN (enables the divide FSM and counter).
//
// Ports:
//   clk, rst          : stage clock, asynchronous active-high reset
//   id_to_exe_valid   : ID holds a valid instruction for EXE
//   div_instr_in      : ID instruction is DIV/DIVU (used only on accept)
//   ex_in             : ID instruction already carries an exception
//   mem_allowin       : MEM can accept this cycle
//   flush             : exception/ERET flush from WB
//   exe_allowin       : EXE register load enable
//   exe_valid         : EXE register holds a live instruction
//   exe_ready_go      : EXE result is complete
//   exe_to_mem_valid  : EXE hands off to MEM
//   div_start         : one-cycle divider start pulse
//   div_busy          : divider running
//   div_abort         : one-cycle divider cancel pulse
module exe_stage_ctrl #(
    parameter int DIV_CYCLES = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic id_to_exe_valid,
    input  logic div_instr_in,
    input  logic ex_in,
    input  logic mem_allowin,
    input  logic flush,
    output logic exe_allowin,
    output logic exe_valid,
    output logic exe_ready_go,
    output logic exe_to_mem_valid,
    output logic div_start,
    output logic div_busy,
    output logic div_abort
);

    logic r_valid;

    assign exe_valid        = r_valid;
    assign exe_allowin      = !r_valid || (exe_ready_go && mem_allowin);
    assign exe_to_mem_valid = r_valid && exe_ready_go && !flush;

    // Flush wins over any load; otherwise reload on every allowin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (exe_allowin) begin
            r_valid <= id_to_exe_valid;
        end
    end

`ifdef EXE_DIV_STALL_EN

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_div_start;
    logic          r_div_abort;
    logic          w_accept;
    logic          w_div_go;
    logic          w_handoff;

    assign w_accept  = id_to_exe_valid && exe_allowin;
    assign w_div_go  = w_accept && div_instr_in && !ex_in;
    assign w_handoff = r_valid && exe_ready_go && mem_allowin;

    assign exe_ready_go = (r_state != S_BUSY);
    assign div_busy     = (r_state == S_BUSY);
    assign div_start    = r_div_start;
    assign div_abort    = r_div_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div_start <= 1'b0;
            r_div_abort <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_div_abort <= 1'b0;
            if (flush) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_div_abort <= (r_state == S_BUSY);
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_div_go) begin
                            r_state     <= S_BUSY;
                            r_cnt       <= CW'(DIV_CYCLES - 1);
                            r_div_start <= 1'b1;
                        end
                    end
                    S_BUSY: begin
                        // Counter parks at zero; DONE follows on the next edge.
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    S_DONE: begin
                        // Handoff may chain straight into a new divide.
                        if (w_handoff) begin
                            if (w_div_go) begin
                                r_state     <= S_BUSY;
                                r_cnt       <= CW'(DIV_CYCLES - 1);
                                r_div_start <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

`else

    // Divide stall compiled out: EXE always completes in one cycle.
    logic w_unused;

    assign w_unused     = ^{div_instr_in, ex_in};
    assign exe_ready_go = 1'b1;
    assign div_start    = 1'b0;
    assign div_busy     = 1'b0;
    assign div_abort    = 1'b0;

`endif

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Self-checking bench for exe_stage_ctrl.
// Divide-specific scenarios follow the EXE_DIV_STALL_EN build setting.
module tb_exe_stage_ctrl;

    localparam int DC = 33;

    logic clk = 1'b0;
    logic rst;
    logic id_to_exe_valid;
    logic div_instr_in;
    logic ex_in;
    logic mem_allowin;
    logic flush;
    logic exe_allowin;
    logic exe_valid;
    logic exe_ready_go;
    logic exe_to_mem_valid;
    logic div_start;
    logic div_busy;
    logic div_abort;

    int cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    int exp_q[$];

    exe_stage_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_to_exe_valid  (id_to_exe_valid),
        .div_instr_in     (div_instr_in),
        .ex_in            (ex_in),
        .mem_allowin      (mem_allowin),
        .flush            (flush),
        .exe_allowin      (exe_allowin),
        .exe_valid        (exe_valid),
        .exe_ready_go     (exe_ready_go),
        .exe_to_mem_valid (exe_to_mem_valid),
        .div_start        (div_start),
        .div_busy         (div_busy),
        .div_abort        (div_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every handoff pops the edge number it was expected on.
    always @(negedge clk) begin
        #3;
        if (!rst && exe_to_mem_valid && mem_allowin) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL handoff_unexpected: edge %0d, none expected",
                         cyc + 1);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc + 1 !== e)
                    $display("FAIL handoff_edge: got %0d expected %0d",
                             cyc + 1, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive(input logic v, input logic d, input logic x,
                         input logic m, input logic f);
        @(negedge clk);
        id_to_exe_valid = v;
        div_instr_in    = d;
        ex_in           = x;
        mem_allowin     = m;
        flush           = f;
        #1;
    endtask

    task automatic idle2();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        logic [6:0] got;
        @(negedge clk);
        #1;
        got = {exe_valid, exe_ready_go, exe_to_mem_valid, exe_allowin,
               div_start, div_busy, div_abort};
        n_chk++;
        if (got !== 7'b0101000)
            $display("FAIL reset_outputs: got %b expected %b", got, 7'b0101000);
        else
            n_pass++;
        // First accept on the first edge after release.
        @(negedge clk);
        rst             = 1'b0;
        id_to_exe_valid = 1'b1;
        mem_allowin     = 1'b1;
        #1;
        exp_q.push_back(cyc + 2);
        n_chk++;
        if (exe_allowin !== 1'b1)
            $display("FAIL reset_allowin: got %b expected 1", exe_allowin);
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({exe_valid, exe_to_mem_valid} !== 2'b11)
            $display("FAIL reset_first_accept: got %b expected 11",
                     {exe_valid, exe_to_mem_valid});
        else
            n_pass++;
    endtask

    task automatic test_stream();
        idle2();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1, 0);
            exp_q.push_back(cyc + 2);
            n_chk++;
            if ({exe_allowin, exe_to_mem_valid} !== {1'b1, (i > 0)})
                $display("FAIL stream_%0d: got %b expected %b", i,
                         {exe_allowin, exe_to_mem_valid}, {1'b1, (i > 0)});
            else
                n_pass++;
        end
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if (exe_to_mem_valid !== 1'b1)
            $display("FAIL stream_tail: got %b expected 1", exe_to_mem_valid);
        else
            n_pass++;
    endtask

    task automatic test_backpressure();
        idle2();
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            n_chk++;
            if ({exe_allowin, exe_valid} !== 2'b01)
                $display("FAIL bp_hold_%0d: got %b expected 01", i,
                         {exe_allowin, exe_valid});
            else
                n_pass++;
        end
        drive(0, 0, 0, 1, 0);
        exp_q.push_back(cyc + 1);
        n_chk++;
        if ({exe_allowin, exe_valid} !== 2'b11)
            $display("FAIL bp_release: got %b expected 11",
                     {exe_allowin, exe_valid});
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if (exe_valid !== 1'b0)
            $display("FAIL bp_drain: got %b expected 0", exe_valid);
        else
            n_pass++;
    endtask

    task automatic test_div();
        int a;
        logic [4:0] got;
        logic [4:0] exp;
        idle2();
        drive(1, 1, 0, 1, 0);
        a = cyc + 1;
`ifdef EXE_DIV_STALL_EN
        // DONE is held three cycles by MEM backpressure before handoff.
        exp_q.push_back(a + DC + 4);
        for (int k = 1; k <= DC + 4; k++) begin
            drive(0, 0, 0, (k >= DC + 4), 0);
            got = {div_start, div_busy, exe_ready_go, exe_allowin, exe_valid};
            exp = {(k == 1), (k <= DC), (k > DC), (k == DC + 4), 1'b1};
            n_chk++;
            if (got !== exp)
                $display("FAIL div_cycle_%0d: got %b expected %b", k, got, exp);
            else
                n_pass++;
        end
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({exe_valid, div_busy} !== 2'b00)
            $display("FAIL div_drain: got %b expected 00",
                     {exe_valid, div_busy});
        else
            n_pass++;
`else
        exp_q.push_back(a + 1);
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({div_start, div_busy, exe_ready_go, exe_to_mem_valid} !== 4'b0011)
            $display("FAIL div_ignored: got %b expected 0011",
                     {div_start, div_busy, exe_ready_go, exe_to_mem_valid});
        else
            n_pass++;
`endif
    endtask

    task automatic test_flush();
        idle2();
`ifdef EXE_DIV_STALL_EN
        drive(1, 1, 0, 1, 0);
        for (int k = 1; k < 10; k++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        n_chk++;
        if ({exe_to_mem_valid, div_busy} !== 2'b01)
            $display("FAIL flush_busy: got %b expected 01",
                     {exe_to_mem_valid, div_busy});
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({div_abort, exe_valid, div_busy, exe_ready_go, exe_allowin}
            !== 5'b10011)
            $display("FAIL flush_abort: got %b expected 10011",
                     {div_abort, exe_valid, div_busy, exe_ready_go,
                      exe_allowin});
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if (div_abort !== 1'b0)
            $display("FAIL flush_abort_once: got %b expected 0", div_abort);
        else
            n_pass++;
`endif
        // Flush coinciding with a divide accept: nothing starts.
        drive(1, 1, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({exe_valid, div_start, div_busy} !== 3'b000)
            $display("FAIL flush_accept: got %b expected 000",
                     {exe_valid, div_start, div_busy});
        else
            n_pass++;
        // Flush of a non-divide: no handoff and no abort.
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        n_chk++;
        if ({exe_valid, exe_to_mem_valid} !== 2'b10)
            $display("FAIL flush_nodiv: got %b expected 10",
                     {exe_valid, exe_to_mem_valid});
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({exe_valid, div_abort} !== 2'b00)
            $display("FAIL flush_nodiv_after: got %b expected 00",
                     {exe_valid, div_abort});
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
`ifdef EXE_DIV_STALL_EN
        int a;
        int b;
        idle2();
        drive(1, 1, 0, 1, 0);
        a = cyc + 1;
        exp_q.push_back(a + DC + 1);
        for (int k = 1; k <= DC; k++) drive(0, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        b = cyc + 1;
        exp_q.push_back(b + DC + 1);
        n_chk++;
        if ({exe_allowin, exe_ready_go} !== 2'b11)
            $display("FAIL b2b_done: got %b expected 11",
                     {exe_allowin, exe_ready_go});
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({div_start, div_busy, exe_valid} !== 3'b111)
            $display("FAIL b2b_restart: got %b expected 111",
                     {div_start, div_busy, exe_valid});
        else
            n_pass++;
        for (int k = 2; k <= DC + 1; k++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({exe_valid, div_busy} !== 2'b00)
            $display("FAIL b2b_drain: got %b expected 00",
                     {exe_valid, div_busy});
        else
            n_pass++;
`endif
    endtask

    task automatic test_ex_in();
        idle2();
        drive(1, 1, 1, 1, 0);
        exp_q.push_back(cyc + 2);
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if ({div_start, div_busy, exe_ready_go, exe_to_mem_valid} !== 4'b0011)
            $display("FAIL ex_in_div: got %b expected 0011",
                     {div_start, div_busy, exe_ready_go, exe_to_mem_valid});
        else
            n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [6:0] got;
        idle2();
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0);
        n_chk++;
        if (exe_valid !== 1'b1)
            $display("FAIL rst_mid_pre: got %b expected 1", exe_valid);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        got = {exe_valid, exe_ready_go, exe_to_mem_valid, exe_allowin,
               div_start, div_busy, div_abort};
        n_chk++;
        if (got !== 7'b0101000)
            $display("FAIL rst_mid: got %b expected 0101000", got);
        else
            n_pass++;
        drive(0, 0, 0, 1, 0);
        n_chk++;
        if (div_abort !== 1'b0)
            $display("FAIL rst_mid_abort: got %b expected 0", div_abort);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        id_to_exe_valid = 1'b0;
        div_instr_in    = 1'b0;
        ex_in           = 1'b0;
        mem_allowin     = 1'b0;
        flush           = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_div();
        test_flush();
        test_back_to_back();
        test_ex_in();
        test_rst_mid();
        idle2();
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_empty: %0d left expected 0",
                     exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exe_stage_ctrl.md
EXE_STAGE_CTRL -- requirements
Module: exe_stage_ctrl

Interface
REQ-001 The block SHALL have a parameter DIV_CYCLES, default 33, giving the number of EXE cycles a divide occupies (range 2..64).
REQ-002 The block SHALL use a clock/reset scheme with one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  stage clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 id_to_exe_valid  in  1  ID holds a valid instruction for EXE.
REQ-006 div_instr_in  in  1  ID instruction is DIV/DIVU; sampled only on accept.
REQ-007 ex_in  in  1  ID instruction already carries an exception; sampled only on accept.
REQ-008 mem_allowin  in  1  MEM can accept this cycle.
REQ-009 flush  in  1  exception/ERET flush from WB.
REQ-010 exe_allowin  out  1  EXE register may load this cycle; drives exe_pipe_reg load enable.
REQ-011 exe_valid  out  1  EXE register holds a live instruction.
REQ-012 exe_ready_go  out  1  EXE result is complete.
REQ-013 exe_to_mem_valid  out  1  EXE hands off to MEM.
REQ-014 div_start  out  1  one-cycle pulse that starts the divider.
REQ-015 div_busy  out  1  divider is running.
REQ-016 div_abort  out  1  one-cycle pulse that cancels a running divide.

Function
REQ-017 accept SHALL be id_to_exe_valid && exe_allowin, and handoff SHALL be exe_valid && exe_ready_go && mem_allowin.
REQ-018 exe_allowin SHALL be combinational: !exe_valid || (exe_ready_go && mem_allowin).
REQ-019 exe_valid SHALL clear on the edge after flush is high (flush has priority); otherwise it SHALL load id_to_exe_valid on every edge where exe_allowin is high, and it SHALL hold when exe_allowin is low.
REQ-020 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-021 In IDLE, exe_ready_go SHALL be 1.
REQ-022 In IDLE, accept with div_instr_in && !ex_in SHALL move the machine to BUSY, load the counter with DIV_CYCLES-1 and assert div_start for exactly the first EXE cycle.
REQ-023 In BUSY, exe_ready_go SHALL be 0, div_busy SHALL be 1, and the counter SHALL decrement by 1 per cycle.
REQ-024 In BUSY, when the counter reaches 0, the machine SHALL move to DONE on the next edge.
REQ-025 In DONE, exe_ready_go SHALL be 1; on handoff the machine SHALL move to IDLE, or to BUSY (reloading the counter and pulsing div_start) if the same edge accepts a qualifying divide.
REQ-026 When DONE is reached and mem_allowin is low, the machine SHALL hold in DONE with no counter wrap.
REQ-027 An accept with ex_in high or div_instr_in low SHALL never enter BUSY.
REQ-028 The counter width SHALL be clog2(DIV_CYCLES), and the counter SHALL never underflow below 0.
REQ-029 exe_to_mem_valid SHALL be exe_valid && exe_ready_go && !flush.
REQ-030 flush SHALL force IDLE, counter 0 and div_start 0 on the next edge.
REQ-031 flush SHALL pulse div_abort for 1 cycle only if the state was BUSY.
REQ-032 When flush and accept coincide, flush SHALL win and no divide SHALL start.
REQ-033 Total EXE occupancy of a divide SHALL be DIV_CYCLES+1 cycles from the accept edge to the first cycle in which handoff is possible.

Reset
REQ-034 rst SHALL asynchronously force exe_valid=0, state=IDLE, counter=0, div_start=0 and div_abort=0, which gives div_busy=0, exe_ready_go=1, exe_to_mem_valid=0 and exe_allowin=1.
REQ-035 rst asserted mid-divide SHALL abandon the divide without a div_abort pulse.
REQ-036 The first accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-037 With macro EXE_DIV_STALL_EN defined, the divide state machine and counter SHALL be implemented as specified above.
REQ-038 Without EXE_DIV_STALL_EN, div_instr_in SHALL be ignored, the state SHALL stay IDLE, div_start/div_busy/div_abort SHALL be tied 0, exe_ready_go SHALL be tied 1, and all exe_valid/allowin behaviour SHALL be unchanged.

Verification
REQ-039 Non-divide stream: id_to_exe_valid=1 and mem_allowin=1 for 5 cycles -> exe_allowin=1 throughout and exe_to_mem_valid=1 from cycle 1.
REQ-040 Backpressure: a valid instruction is in EXE and mem_allowin=0 -> exe_allowin=0 and exe_valid holds 1 until mem_allowin rises.
REQ-041 Divide with DIV_CYCLES=33: accept at edge 0 -> div_start=1 in cycle 1 only, div_busy=1 for 33 cycles, exe_ready_go rises in cycle 34, and exe_allowin stays 0 meanwhile.
REQ-042 flush in cycle 10 of a divide -> div_abort=1 for 1 cycle, exe_valid=0, state IDLE, and exe_allowin=1 next cycle.
REQ-043 Back-to-back divides: a DONE handoff coinciding with accept of a second DIV -> direct transition to BUSY and a second div_start pulse with no idle gap.
REQ-044 Divide with ex_in=1 -> no div_start, exe_ready_go=1, and handoff in the next cycle; rst asserted mid-BUSY -> all outputs return to reset values immediately.
